alu_issue_controller: RTL

- Sequential front end that sits between the register-read stage and the combinational ALU.
- Accepts one RV32I instruction per transaction over a valid/ready handshake, decodes it into the 5-bit ALU operation code and operands, and drives the ALU.
- Samples the ALU's outputResult/zeroFlag, then presents the result, destination, branch decision and target to writeback/PC logic over a second valid/ready handshake.
- Multi-cycle and non-pipelined: at most one instruction in flight.

---
 rtl/alu_pkg.sv | 66 ++++++
 rtl/alu_issue_controller_if.sv | 50 +++++
 rtl/rv32_decode.sv | 140 ++++++++++++++
 rtl/alu_issue_controller.sv | 115 +++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU op codes, RV32I opcodes, FSM states and the decode bundle.
// Optional illegal-instruction reporting is enabled by defining ILLEGAL_TRAP_EN.
package alu_pkg;

  typedef enum logic [4:0] {
    OP_LUI   = 5'd0,
    OP_AUIPC = 5'd1,
    OP_ADD   = 5'd2,
    OP_BEQ   = 5'd3,
    OP_BNE   = 5'd4,
    OP_BLT   = 5'd5,
    OP_BGE   = 5'd6,
    OP_BLTU  = 5'd7,
    OP_BGEU  = 5'd8,
    OP_SLT   = 5'd9,
    OP_SLTU  = 5'd10,
    OP_XOR   = 5'd11,
    OP_OR    = 5'd12,
    OP_AND   = 5'd13,
    OP_SLL   = 5'd14,
    OP_SRL   = 5'd15,
    OP_SRA   = 5'd16,
    OP_SUB   = 5'd17,
    OP_PASSB = 5'd18
  } alu_op_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  typedef struct packed {
    alu_op_e     op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] target;
    logic        rd_write;
    logic        mem_req;
    logic        mem_write;
    logic        is_branch;
    logic        is_jump;
    logic        illegal;
  } dec_t;

  // funct3 to ALU op for OP/OP-IMM; alt selects SUB or SRA.
  function automatic alu_op_e arith_op(logic [2:0] funct3, logic alt);
    case (funct3)
      3'b000:  arith_op = alt ? OP_SUB : OP_ADD;
      3'b001:  arith_op = OP_SLL;
      3'b010:  arith_op = OP_SLT;
      3'b011:  arith_op = OP_SLTU;
      3'b100:  arith_op = OP_XOR;
      3'b101:  arith_op = alt ? OP_SRA : OP_SRL;
      3'b110:  arith_op = OP_OR;
      default: arith_op = OP_AND;
    endcase
  endfunction

endpackage

// File: rtl/alu_issue_controller_if.sv
// Issue, ALU and result handshake bundle for alu_issue_controller.
// illegalInstr exists only when ILLEGAL_TRAP_EN is defined.
interface alu_issue_controller_if;
  logic        inValid;
  logic        inReady;
  logic [31:0] instruction;
  logic [31:0] pcIn;
  logic [31:0] rs1Data;
  logic [31:0] rs2Data;
  logic [4:0]  aluOp;
  logic [31:0] aluA;
  logic [31:0] aluB;
  logic [31:0] aluResult;
  logic        aluZero;
  logic        outValid;
  logic        outReady;
  logic [31:0] resultData;
  logic [4:0]  rdIndex;
  logic        rdWrite;
  logic        memReq;
  logic        memWrite;
  logic        branchTaken;
  logic [31:0] branchTarget;
  logic [31:0] pcOut;
`ifdef ILLEGAL_TRAP_EN
  logic        illegalInstr;

  modport slave (
    input  inValid, instruction, pcIn, rs1Data, rs2Data, aluResult, aluZero, outReady,
    output inReady, aluOp, aluA, aluB, outValid, resultData, rdIndex, rdWrite, memReq,
    output memWrite, branchTaken, branchTarget, pcOut, illegalInstr
  );
  modport master (
    output inValid, instruction, pcIn, rs1Data, rs2Data, aluResult, aluZero, outReady,
    input  inReady, aluOp, aluA, aluB, outValid, resultData, rdIndex, rdWrite, memReq,
    input  memWrite, branchTaken, branchTarget, pcOut, illegalInstr
  );
`else
  modport slave (
    input  inValid, instruction, pcIn, rs1Data, rs2Data, aluResult, aluZero, outReady,
    output inReady, aluOp, aluA, aluB, outValid, resultData, rdIndex, rdWrite, memReq,
    output memWrite, branchTaken, branchTarget, pcOut
  );
  modport master (
    output inValid, instruction, pcIn, rs1Data, rs2Data, aluResult, aluZero, outReady,
    input  inReady, aluOp, aluA, aluB, outValid, resultData, rdIndex, rdWrite, memReq,
    input  memWrite, branchTaken, branchTarget, pcOut
  );
`endif
endinterface

// File: rtl/rv32_decode.sv
// Combinational RV32I decode: ALU op, operands, branch/jump target and side-effect flags.
// Unrecognised encodings decode to a PASSB no-op with illegal set.
module rv32_decode
  import alu_pkg::*;
(
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_rs1,
  input  logic [31:0] i_rs2,
  output dec_t        o_dec
);

  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [6:0]  w_funct7;
  logic        w_rd_nz;
  logic [31:0] w_imm_i;
  logic [31:0] w_imm_s;
  logic [31:0] w_imm_b;
  logic [31:0] w_imm_u;
  logic [31:0] w_imm_j;

  assign w_opcode = i_instr[6:0];
  assign w_funct3 = i_instr[14:12];
  assign w_funct7 = i_instr[31:25];
  assign w_rd_nz  = (i_instr[11:7] != 5'd0);
  assign w_imm_i  = {{20{i_instr[31]}}, i_instr[31:20]};
  assign w_imm_s  = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
  assign w_imm_b  = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25],
                     i_instr[11:8], 1'b0};
  assign w_imm_u  = {i_instr[31:12], 12'b0};
  assign w_imm_j  = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20],
                     i_instr[30:21], 1'b0};

  always_comb begin
    o_dec         = '0;
    o_dec.op      = OP_PASSB;
    o_dec.illegal = 1'b1;
    case (w_opcode)
      OPC_LUI: begin
        o_dec.illegal  = 1'b0;
        o_dec.op       = OP_LUI;
        o_dec.b        = w_imm_u;
        o_dec.rd_write = w_rd_nz;
      end
      OPC_AUIPC: begin
        o_dec.illegal  = 1'b0;
        o_dec.op       = OP_AUIPC;
        o_dec.a        = i_pc;
        o_dec.b        = w_imm_u;
        o_dec.rd_write = w_rd_nz;
      end
      OPC_OP_IMM: begin
        if (w_funct3 == 3'b001) begin
          o_dec.illegal = (w_funct7 != 7'h00);
        end else if (w_funct3 == 3'b101) begin
          o_dec.illegal = (w_funct7 != 7'h00) && (w_funct7 != 7'h20);
        end else begin
          o_dec.illegal = 1'b0;
        end
        if (!o_dec.illegal) begin
          o_dec.op       = arith_op(w_funct3, (w_funct3 == 3'b101) && w_funct7[5]);
          o_dec.a        = i_rs1;
          o_dec.b        = (w_funct3[1:0] == 2'b01) ? {27'b0, i_instr[24:20]} : w_imm_i;
          o_dec.rd_write = w_rd_nz;
        end
      end
      OPC_OP: begin
        o_dec.illegal = !((w_funct7 == 7'h00) ||
                          ((w_funct7 == 7'h20) && ((w_funct3 == 3'b000) ||
                                                   (w_funct3 == 3'b101))));
        if (!o_dec.illegal) begin
          o_dec.op       = arith_op(w_funct3, w_funct7[5]);
          o_dec.a        = i_rs1;
          o_dec.b        = i_rs2;
          o_dec.rd_write = w_rd_nz;
        end
      end
      OPC_LOAD: begin
        o_dec.illegal = (w_funct3 == 3'b011) || (w_funct3[2:1] == 2'b11);
        if (!o_dec.illegal) begin
          o_dec.op       = OP_ADD;
          o_dec.a        = i_rs1;
          o_dec.b        = w_imm_i;
          o_dec.mem_req  = 1'b1;
          o_dec.rd_write = w_rd_nz;
        end
      end
      OPC_STORE: begin
        o_dec.illegal = (w_funct3 > 3'b010);
        if (!o_dec.illegal) begin
          o_dec.op        = OP_ADD;
          o_dec.a         = i_rs1;
          o_dec.b         = w_imm_s;
          o_dec.mem_req   = 1'b1;
          o_dec.mem_write = 1'b1;
        end
      end
      OPC_BRANCH: begin
        o_dec.illegal = (w_funct3[2:1] == 2'b01);
        if (!o_dec.illegal) begin
          case (w_funct3)
            3'b000:  o_dec.op = OP_BEQ;
            3'b001:  o_dec.op = OP_BNE;
            3'b100:  o_dec.op = OP_BLT;
            3'b101:  o_dec.op = OP_BGE;
            3'b110:  o_dec.op = OP_BLTU;
            default: o_dec.op = OP_BGEU;
          endcase
          o_dec.a         = i_rs1;
          o_dec.b         = i_rs2;
          o_dec.is_branch = 1'b1;
          o_dec.target    = i_pc + w_imm_b;
        end
      end
      OPC_JAL: begin
        o_dec.illegal  = 1'b0;
        o_dec.op       = OP_ADD;
        o_dec.a        = i_pc;
        o_dec.b        = 32'd4;
        o_dec.is_jump  = 1'b1;
        o_dec.target   = i_pc + w_imm_j;
        o_dec.rd_write = w_rd_nz;
      end
      OPC_JALR: begin
        o_dec.illegal = (w_funct3 != 3'b000);
        if (!o_dec.illegal) begin
          o_dec.op       = OP_ADD;
          o_dec.a        = i_pc;
          o_dec.b        = 32'd4;
          o_dec.is_jump  = 1'b1;
          o_dec.target   = (i_rs1 + w_imm_i) & ~32'd1;
          o_dec.rd_write = w_rd_nz;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_issue_controller.sv
// Non-pipelined IDLE -> EXEC -> RESP issue controller in front of a combinational ALU.
// Defining ILLEGAL_TRAP_EN adds the registered illegalInstr result flag.
module alu_issue_controller
  import alu_pkg::*;
#(
  parameter int unsigned XLEN          = 32,
  parameter logic [31:0] RESET_PC_INFO = 32'h0
) (
  input  logic                   clk,
  input  logic                   reset,
  alu_issue_controller_if.slave  io_bus
);

  state_e            r_state;
  logic [XLEN-1:0]   r_instr;
  logic [XLEN-1:0]   r_pc;
  logic [XLEN-1:0]   r_rs1;
  logic [XLEN-1:0]   r_rs2;
  logic              r_out_valid;
  logic [XLEN-1:0]   r_result;
  logic [4:0]        r_rd_index;
  logic              r_rd_write;
  logic              r_mem_req;
  logic              r_mem_write;
  logic              r_branch_taken;
  logic [XLEN-1:0]   r_target;
  logic [XLEN-1:0]   r_pc_out;
  logic              r_illegal;
  dec_t              w_dec;

  // Decode works off the captured instruction, so a reset instruction word of 0
  // (illegal opcode) naturally presents PASSB with zero operands.
  rv32_decode u_decode (
    .i_instr (r_instr),
    .i_pc    (r_pc),
    .i_rs1   (r_rs1),
    .i_rs2   (r_rs2),
    .o_dec   (w_dec)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= StIdle;
      r_instr        <= '0;
      r_pc           <= '0;
      r_rs1          <= '0;
      r_rs2          <= '0;
      r_out_valid    <= 1'b0;
      r_result       <= '0;
      r_rd_index     <= '0;
      r_rd_write     <= 1'b0;
      r_mem_req      <= 1'b0;
      r_mem_write    <= 1'b0;
      r_branch_taken <= 1'b0;
      r_target       <= '0;
      r_pc_out       <= RESET_PC_INFO;
      r_illegal      <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (io_bus.inValid) begin
            r_instr <= io_bus.instruction;
            r_pc    <= io_bus.pcIn;
            r_rs1   <= io_bus.rs1Data;
            r_rs2   <= io_bus.rs2Data;
            r_state <= StExec;
          end
        end
        StExec: begin
          r_result       <= io_bus.aluResult;
          r_rd_index     <= r_instr[11:7];
          r_rd_write     <= w_dec.rd_write;
          r_mem_req      <= w_dec.mem_req;
          r_mem_write    <= w_dec.mem_write;
          // zeroFlag carries the compare outcome only for branch ops
          r_branch_taken <= w_dec.is_branch ? io_bus.aluZero : w_dec.is_jump;
          r_target       <= w_dec.target;
          r_pc_out       <= r_pc;
          r_illegal      <= w_dec.illegal;
          r_out_valid    <= 1'b1;
          r_state        <= StResp;
        end
        StResp: begin
          if (io_bus.outReady) begin
            r_out_valid <= 1'b0;
            r_state     <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign io_bus.inReady      = (r_state == StIdle);
  assign io_bus.aluOp        = w_dec.op;
  assign io_bus.aluA         = w_dec.a;
  assign io_bus.aluB         = w_dec.b;
  assign io_bus.outValid     = r_out_valid;
  assign io_bus.resultData   = r_result;
  assign io_bus.rdIndex      = r_rd_index;
  assign io_bus.rdWrite      = r_rd_write;
  assign io_bus.memReq       = r_mem_req;
  assign io_bus.memWrite     = r_mem_write;
  assign io_bus.branchTaken  = r_branch_taken;
  assign io_bus.branchTarget = r_target;
  assign io_bus.pcOut        = r_pc_out;

`ifdef ILLEGAL_TRAP_EN
  assign io_bus.illegalInstr = r_illegal;
`else
  logic w_unused_illegal;
  assign w_unused_illegal = r_illegal;
`endif

endmodule
